// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   // Fetch sequencing: present request, wait for response, hold for decode.
   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   // Byte distance between consecutive sequential instructions.
   localparam int PC_STEP = 4;

   // Default instruction and address widths.
   localparam int DEFAULT_INSTR_W = 32;
   localparam int DEFAULT_XLEN    = 64;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and decode hand-off signals.
// master: the fetch stage. slave: memory + decode environment.
interface fetch_unit_if #(
   parameter int XLEN    = 64,
   parameter int INSTR_W = 32
);
   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [XLEN-1:0]    imem_req_addr;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               if_valid;
   logic               if_ready;
   logic [XLEN-1:0]    if_pc;
   logic [INSTR_W-1:0] if_instr;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output if_valid, if_pc, if_instr,
      input  if_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  if_valid, if_pc, if_instr,
      output if_ready
   );
endinterface

// File: rtl/fetch_pc_reg.sv
// Architectural PC register: reset value, taken-branch redirect (word aligned)
// and sequential +PC_STEP advance. Redirect always wins over advance.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            advance,
   output logic [XLEN-1:0] pc
);

   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_q;

   // Next-PC select; the low two target bits are forced to zero, +4 wraps naturally.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
      end else if (advance) begin
         pc_d = pc_q + XLEN'(PC_STEP);
      end else begin
         pc_d = pc_q;
      end
   end

   // PC state with asynchronous reset to the boot address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit_chk.sv
// Protocol checker for the fetch stage: memory may only respond while a
// request is outstanding.
module fetch_unit_chk (
   input logic clk,
   input logic reset,
   input logic in_wait,
   input logic rsp_valid
);

   // A response outside the waiting state is a memory protocol violation.
   rsp_only_in_wait: assert property (@(posedge clk) disable iff (reset) rsp_valid |-> in_wait)
      else $error("fetch_unit: imem response arrived with no outstanding request");

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues one instruction-memory request
// at a time, delivers {pc, instr} to decode and honours taken-branch redirects,
// discarding the response of any request that a redirect made wrong-path.
// Optional feature macro: FETCH_STALL_CNT_EN adds the saturating stall_cycles counter.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = DEFAULT_XLEN,
   parameter int              INSTR_W  = DEFAULT_INSTR_W,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   fetch_unit_if.master    bus
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0]     stall_cycles
`endif
);

   fetch_state_e       state_d, state_q;
   logic               drop_d, drop_q;
   logic               if_valid_d, if_valid_q;
   logic [XLEN-1:0]    if_pc_d, if_pc_q;
   logic [INSTR_W-1:0] if_instr_d, if_instr_q;
   logic               advance;
   logic [XLEN-1:0]    pc;

   fetch_pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .advance        (advance),
      .pc             (pc)
   );

   // The PC steps only when a good-path response is captured for decode.
   always_comb begin
      advance = 1'b0;
      if ((state_q == WAIT) && bus.imem_rsp_valid && !drop_q && !redirect_valid) begin
         advance = 1'b1;
      end else begin
         advance = 1'b0;
      end
   end

   // Next-state and output-register values; a redirect squashes whatever is in flight.
   always_comb begin
      state_d    = state_q;
      drop_d     = drop_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      case (state_q)
         REQ: begin
            if (bus.imem_req_ready) begin
               // The old address is already accepted; remember to discard its data.
               state_d = WAIT;
               drop_d  = redirect_valid;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (bus.imem_rsp_valid) begin
               if (drop_q || redirect_valid) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  if_instr_d = bus.imem_rsp_data;
                  if_pc_d    = pc;
                  if_valid_d = 1'b1;
                  state_d    = HOLD;
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
            end else begin
               drop_d = drop_q;
            end
         end
         HOLD: begin
            if (redirect_valid || bus.if_ready) begin
               if_valid_d = 1'b0;
               state_d    = REQ;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d    = REQ;
            drop_d     = 1'b0;
            if_valid_d = 1'b0;
         end
      endcase
   end

   // FSM, wrong-path flag and registered decode outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= REQ;
         drop_q     <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= {XLEN{1'b0}};
         if_instr_q <= {INSTR_W{1'b0}};
      end else begin
         state_q    <= state_d;
         drop_q     <= drop_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
      end
   end

   assign bus.imem_req_valid = (state_q == REQ);
   assign bus.imem_req_addr  = pc;
   assign bus.if_valid       = if_valid_q;
   assign bus.if_pc          = if_pc_q;
   assign bus.if_instr       = if_instr_q;

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_d, stall_q;
   logic        stall_event;

   // A cycle stalls when the request is refused, memory is pending, or decode is not taking.
   always_comb begin
      stall_event = ((state_q == REQ) && !bus.imem_req_ready) ||
                    (state_q == WAIT) ||
                    ((state_q == HOLD) && !bus.if_ready);
      if (stall_event && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end else begin
         stall_d = stall_q;
      end
   end

   // Saturating stall counter, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= 32'd0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

   fetch_unit_chk u_chk (
      .clk       (clk),
      .reset     (reset),
      .in_wait   (state_q == WAIT),
      .rsp_valid (bus.imem_rsp_valid)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all judged by a transaction-level model of the fetch stage.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   fetch_unit_if #(.XLEN(64), .INSTR_W(32)) bus ();

   fetch_unit #(.XLEN(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus)
`ifdef FETCH_STALL_CNT_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Knobs for the environment
   int p_rdy   = 100;
   int p_ifr   = 100;
   int lat_min = 1;
   int lat_max = 1;

   // Model: architectural pc, outstanding request, instruction awaiting decode
   logic [63:0] m_pc;
   logic        m_out_v;
   logic        m_out_wrong;
   logic [63:0] m_out_addr;
   logic        m_hold_v;
   logic [63:0] m_hold_pc;
   logic [31:0] m_hold_instr;
   int          mem_delay;
   logic [63:0] m_stall;
   int          n_deliv;
   int          cyc;
   int          last_cyc;
   int          last_gap;
   logic [63:0] deliv_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   // One clock cycle: called at a falling edge, checks outputs, drives inputs,
   // advances the model across the coming rising edge.
   task automatic step(input logic rv, input logic [63:0] rpc);
      logic rdy, ifr, rsp, m_req;
      m_req = !m_out_v && !m_hold_v;
      check("req_valid", {63'd0, bus.imem_req_valid}, {63'd0, m_req});
      if (m_req) check("req_addr", bus.imem_req_addr, m_pc);
      check("if_valid", {63'd0, bus.if_valid}, {63'd0, m_hold_v});
      if (m_hold_v) begin
         check("if_pc", bus.if_pc, m_hold_pc);
         check("if_instr", {32'd0, bus.if_instr}, {32'd0, m_hold_instr});
      end
`ifdef FETCH_STALL_CNT_EN
      check("stall_cycles", {32'd0, stall_cycles}, m_stall);
`endif
      rdy = ($urandom_range(99) < p_rdy);
      ifr = ($urandom_range(99) < p_ifr);
      rsp = m_out_v && (mem_delay == 0);
      bus.imem_req_ready = rdy;
      bus.if_ready       = ifr;
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? mem_word(m_out_addr) : $urandom();
      redirect_valid     = rv;
      redirect_pc        = rpc;

      if ((m_req && !rdy) || m_out_v || (m_hold_v && !ifr)) m_stall = m_stall + 64'd1;
      if (m_hold_v) begin
         if (rv) begin
            m_hold_v = 1'b0;
         end else if (ifr) begin
            m_hold_v = 1'b0;
            n_deliv++;
            deliv_q.push_back(m_hold_pc);
            last_gap = cyc - last_cyc;
            last_cyc = cyc;
         end
      end
      if (rsp) begin
         m_out_v = 1'b0;
         if (!m_out_wrong && !rv) begin
            m_hold_v     = 1'b1;
            m_hold_pc    = m_out_addr;
            m_hold_instr = mem_word(m_out_addr);
            m_pc         = m_out_addr + 64'd4;
         end
      end else if (m_out_v) begin
         if (rv) m_out_wrong = 1'b1;
         mem_delay--;
      end
      if (m_req && rdy) begin
         m_out_v     = 1'b1;
         m_out_addr  = m_pc;
         m_out_wrong = rv;
         mem_delay   = $urandom_range(lat_max - 1, lat_min - 1);
      end
      if (rv) m_pc = {rpc[63:2], 2'b00};
      cyc++;
      @(negedge clk);
   endtask

   // Hold reset (with a redirect pulse that must be ignored), then release.
   task automatic do_reset();
      reset              = 1'b1;
      redirect_valid     = 1'b1;
      redirect_pc        = 64'h5557;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      bus.if_ready       = 1'b0;
      m_pc = 64'h0; m_out_v = 1'b0; m_out_wrong = 1'b0; m_out_addr = 64'h0;
      m_hold_v = 1'b0; m_hold_pc = 64'h0; m_hold_instr = 32'd0;
      mem_delay = 0; m_stall = 64'd0;
      repeat (2) @(negedge clk);
      check("rst_if_valid", {63'd0, bus.if_valid}, 64'd0);
      check("rst_if_pc", bus.if_pc, 64'd0);
      check("rst_if_instr", {32'd0, bus.if_instr}, 64'd0);
      check("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
      check("rst_req_addr", bus.imem_req_addr, 64'h0);
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      reset          = 1'b0;
   endtask

   initial begin
      int d0;
      logic [63:0] s_pc;
      logic [31:0] s_instr;
      logic saw_v;
      n_deliv = 0; cyc = 0; last_cyc = 0; last_gap = 0;
      do_reset();

      // 1: back-to-back fetch, 1-cycle memory, decode always ready
      for (int i = 0; i < 10; i++) step(1'b0, 64'h0);
      check("t1_count", n_deliv, 3);
      check("t1_pc0", deliv_q[0], 64'h0);
      check("t1_pc1", deliv_q[1], 64'h4);
      check("t1_pc2", deliv_q[2], 64'h8);
      check("t1_spacing", last_gap, 3);

      // 2: redirect while waiting on a 2-cycle response
      lat_min = 2; lat_max = 2;
      for (int i = 0; i < 10 && !m_out_v; i++) step(1'b0, 64'h0);
      check("t2_in_wait", {63'd0, m_out_v}, 64'd1);
      d0 = n_deliv;
      step(1'b1, 64'h1000);
      saw_v = 1'b0;
      for (int i = 0; i < 10 && !bus.imem_req_valid; i++) begin
         saw_v |= bus.if_valid;
         step(1'b0, 64'h0);
      end
      check("t2_req_addr", bus.imem_req_addr, 64'h1000);
      check("t2_no_valid", {63'd0, saw_v | bus.if_valid}, 64'd0);
      check("t2_no_deliv", n_deliv, d0);

      // 3: redirect squashes the held instruction even with decode ready
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 10 && !m_hold_v; i++) step(1'b0, 64'h0);
      check("t3_in_hold", {63'd0, bus.if_valid}, 64'd1);
      d0 = n_deliv;
      step(1'b1, 64'h2003);
      check("t3_squash", {63'd0, bus.if_valid}, 64'd0);
      check("t3_req_addr", bus.imem_req_addr, 64'h2000);
      check("t3_no_deliv", n_deliv, d0);

      // 4: decode back-pressure holds outputs and blocks fetch
      p_ifr = 0;
      for (int i = 0; i < 10 && !m_hold_v; i++) step(1'b0, 64'h0);
      s_pc = bus.if_pc; s_instr = bus.if_instr;
      check("t4_first_pc", s_pc, 64'h2000);
      for (int i = 0; i < 5; i++) step(1'b0, 64'h0);
      check("t4_valid", {63'd0, bus.if_valid}, 64'd1);
      check("t4_pc_stable", bus.if_pc, s_pc);
      check("t4_instr_stable", {32'd0, bus.if_instr}, {32'd0, mem_word(64'h2000)});
      check("t4_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
      p_ifr = 100;

      // 5: pc wraps from the top of the address space
      for (int i = 0; i < 10 && !bus.imem_req_valid; i++) step(1'b0, 64'h0);
      step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      d0 = n_deliv;
      for (int i = 0; i < 20 && n_deliv == d0; i++) step(1'b0, 64'h0);
      check("t5_top_pc", deliv_q[$], 64'hFFFF_FFFF_FFFF_FFFC);
      for (int i = 0; i < 10 && !bus.imem_req_valid; i++) step(1'b0, 64'h0);
      check("t5_wrap_addr", bus.imem_req_addr, 64'h0);

      // 6: asynchronous reset in the middle of a wait
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 10 && !m_out_v; i++) step(1'b0, 64'h0);
      check("t6_in_wait", {63'd0, m_out_v}, 64'd1);
      reset = 1'b1;
      #1;
      check("t6_if_pc_zero", bus.if_pc, 64'd0);
      check("t6_if_instr_zero", {32'd0, bus.if_instr}, 64'd0);
      check("t6_req_now", {63'd0, bus.imem_req_valid}, 64'd1);
      @(negedge clk);
      do_reset();
      p_rdy = 0;
      for (int i = 0; i < 4; i++) step(1'b0, 64'h0);
`ifdef FETCH_STALL_CNT_EN
      check("t6_stall4", {32'd0, stall_cycles}, 64'd4);
`endif
      check("t6_req_addr", bus.imem_req_addr, 64'h0);

      // Random traffic against the model
      p_rdy = 70; p_ifr = 60; lat_min = 1; lat_max = 3;
      d0 = n_deliv;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) < 6)
            step(1'b1, ($urandom_range(9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {32'd0, $urandom()});
         else
            step(1'b0, 64'h0);
      end
      check("rand_progress", {63'd0, (n_deliv - d0) > 20}, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
